// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder MCU sequencer.
//
// Contents:
//   SLOT_*       slot indices of the blocks inside an MCU (Y0..Y3, Cb, Cr)
//   state_e      sequencer states IDLE / CALC / RUN / DONE
//   sampling_e   frame sampling mode: grey or colour 4:4:4 / 4:2:2 / 4:4:0 / 4:2:0
//   decode_mode  maps the raw configuration inputs onto a sampling_e
package aq_djpeg_pkg;

  localparam logic [2:0] SLOT_Y0 = 3'd0;
  localparam logic [2:0] SLOT_Y1 = 3'd1;
  localparam logic [2:0] SLOT_Y2 = 3'd2;
  localparam logic [2:0] SLOT_Y3 = 3'd3;
  localparam logic [2:0] SLOT_CB = 3'd4;
  localparam logic [2:0] SLOT_CR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    GREY,
    S444,
    S422,
    S440,
    S420
  } sampling_e;

  // Only a component count of 3 is treated as colour; a subsampling factor
  // code of 2 means "two blocks" on that axis, every other code means one.
  function automatic sampling_e decode_mode(input logic [2:0] comp,
                                            input logic [1:0] sub_w,
                                            input logic [1:0] sub_h);
    logic w2;
    logic h2;
    sampling_e mode;
    w2 = (sub_w == 2'd2);
    h2 = (sub_h == 2'd2);
    if (comp != 3'd3) begin
      mode = GREY;
    end else begin
      case ({w2, h2})
        2'b00:   mode = S444;
        2'b10:   mode = S422;
        2'b01:   mode = S440;
        default: mode = S420;
      endcase
    end
    return mode;
  endfunction

endpackage

// File: rtl/aq_djpeg_mcu_slot_rom.sv
// Slot sequence table for the MCU sequencer.
//
// Ports:
//   mode  in   sampling mode (aq_djpeg_pkg::sampling_e encoding)
//   ptr   in   position of the current block inside the MCU
//   slot  out  slot index of the block at that position
//   last  out  high when that position is the final block of the MCU
//
// Pointer values beyond a mode's sequence cannot occur in normal operation;
// they map onto the final entry so the sequencer would still wrap.
module aq_djpeg_mcu_slot_rom
  import aq_djpeg_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [2:0] ptr,
  output logic [2:0] slot,
  output logic       last
);

  always_comb begin
    slot = SLOT_Y0;
    last = 1'b0;
    case (sampling_e'(mode))
      GREY: begin
        case (ptr)
          3'd0, 3'd1, 3'd2: slot = ptr;
          default: begin
            slot = SLOT_Y3;
            last = 1'b1;
          end
        endcase
      end
      S444: begin
        case (ptr)
          3'd0: slot = SLOT_Y0;
          3'd1: slot = SLOT_CB;
          default: begin
            slot = SLOT_CR;
            last = 1'b1;
          end
        endcase
      end
      S422: begin
        case (ptr)
          3'd0: slot = SLOT_Y0;
          3'd1: slot = SLOT_Y1;
          3'd2: slot = SLOT_CB;
          default: begin
            slot = SLOT_CR;
            last = 1'b1;
          end
        endcase
      end
      S440: begin
        case (ptr)
          3'd0: slot = SLOT_Y0;
          3'd1: slot = SLOT_Y2;
          3'd2: slot = SLOT_CB;
          default: begin
            slot = SLOT_CR;
            last = 1'b1;
          end
        endcase
      end
      S420: begin
        case (ptr)
          3'd0, 3'd1, 3'd2, 3'd3: slot = ptr;
          3'd4: slot = SLOT_CB;
          default: begin
            slot = SLOT_CR;
            last = 1'b1;
          end
        endcase
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/aq_djpeg_mcu_seq.sv
// MCU sequencer ahead of the YCbCr memory / colour-conversion path.
//
// Orders IDCT block completions into MCU slots (Y0..Y3 = 0..3, Cb = 4,
// Cr = 5), holds off upstream at the start of a bank while the YCbCr memory
// is full, tracks the MCU column/row and flags MCU and frame completion.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ProcessInit         abort pulse, returns to IDLE and clears ErrOverrun
//   Start               begins a frame (only accepted in IDLE)
//   JpegComp, SubSamplingW, SubSamplingH, ImageWidth, ImageHeight
//                       frame configuration, sampled on an accepted Start
//   BankFull            YCbCr memory cannot accept a new bank
//   BlockDone           upstream finished writing the current block
//   BlockReady          upstream may produce/finish the current block
//   BlockColor          slot index of the current block
//   McuX, McuY          current MCU position
//   McuCols             MCUs per row of the current frame
//   McuDone, FrameDone  single-cycle completion pulses
//   Busy                sequencer is not idle
//   ErrOverrun          sticky: BlockDone arrived while BlockReady was low
//   StallCycles         (AQ_DJPEG_MCU_STATS_EN only) saturating count of
//                       RUN cycles spent with BlockReady low
//
// Optional feature macro: AQ_DJPEG_MCU_STATS_EN.
module aq_djpeg_mcu_seq
  import aq_djpeg_pkg::*;
#(
  parameter int MCUW = 12,
  parameter int DIMW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ProcessInit,
  input  logic            Start,
  input  logic [2:0]      JpegComp,
  input  logic [1:0]      SubSamplingW,
  input  logic [1:0]      SubSamplingH,
  input  logic [DIMW-1:0] ImageWidth,
  input  logic [DIMW-1:0] ImageHeight,
  input  logic            BankFull,
  input  logic            BlockDone,
  output logic            BlockReady,
  output logic [2:0]      BlockColor,
  output logic [MCUW-1:0] McuX,
  output logic [MCUW-1:0] McuY,
  output logic [MCUW-1:0] McuCols,
  output logic            McuDone,
  output logic            FrameDone,
  output logic            Busy,
  output logic            ErrOverrun
`ifdef AQ_DJPEG_MCU_STATS_EN
  ,
  output logic [31:0]     StallCycles
`endif
);

  state_e          state_q, state_d;
  sampling_e       mode_q, mode_d;
  logic [DIMW-1:0] width_q, width_d;
  logic [DIMW-1:0] height_q, height_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [MCUW-1:0] mcu_x_q, mcu_x_d;
  logic [MCUW-1:0] mcu_y_q, mcu_y_d;
  logic [MCUW-1:0] mcu_cols_q, mcu_cols_d;
  logic [MCUW-1:0] mcu_rows_q, mcu_rows_d;
  logic            mcu_done_q, mcu_done_d;
  logic            err_q, err_d;

  logic [2:0]      slot;
  logic            slot_last;
  logic            block_ready;
  logic            accept;
  logic            last_col;
  logic            last_row;
  logic [2:0]      w_shift;
  logic [2:0]      h_shift;
  logic [31:0]     w_mask;
  logic [31:0]     h_mask;

  aq_djpeg_mcu_slot_rom u_slot_rom (
    .mode (mode_q),
    .ptr  (ptr_q),
    .slot (slot),
    .last (slot_last)
  );

  // MCU size as log2 of pixels: grey banks are 32x8, colour MCUs are 8 px
  // per Y block along each axis.
  always_comb begin
    w_shift = 3'd3;
    h_shift = 3'd3;
    case (mode_q)
      GREY: w_shift = 3'd5;
      S422: w_shift = 3'd4;
      S440: h_shift = 3'd4;
      S420: begin
        w_shift = 3'd4;
        h_shift = 3'd4;
      end
      default: ;
    endcase
    w_mask = (32'd1 << w_shift) - 32'd1;
    h_mask = (32'd1 << h_shift) - 32'd1;
  end

  // Only the first block of an MCU opens a new bank, so BankFull can only
  // stall at pointer 0.
  assign block_ready = (state_q == RUN) && ((ptr_q != 3'd0) || !BankFull);
  assign accept      = BlockDone && block_ready;
  assign last_col    = (mcu_x_q == (mcu_cols_q - MCUW'(1)));
  assign last_row    = (mcu_y_q == (mcu_rows_q - MCUW'(1)));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    height_d   = height_q;
    ptr_d      = ptr_q;
    mcu_x_d    = mcu_x_q;
    mcu_y_d    = mcu_y_q;
    mcu_cols_d = mcu_cols_q;
    mcu_rows_d = mcu_rows_q;
    mcu_done_d = 1'b0;
    err_d      = err_q;

    if (BlockDone && !block_ready) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d   = decode_mode(JpegComp, SubSamplingW, SubSamplingH);
          width_d  = ImageWidth;
          height_d = ImageHeight;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Round-up division by a power of two; the result is deliberately
        // truncated to the counter width.
        mcu_cols_d = MCUW'((32'(width_q) + w_mask) >> w_shift);
        mcu_rows_d = MCUW'((32'(height_q) + h_mask) >> h_shift);
        mcu_x_d    = '0;
        mcu_y_d    = '0;
        ptr_d      = 3'd0;
        state_d    = RUN;
      end
      RUN: begin
        if (accept) begin
          if (slot_last) begin
            ptr_d      = 3'd0;
            mcu_done_d = 1'b1;
            if (last_col) begin
              // The final position is left visible while the frame closes.
              if (last_row) begin
                state_d = DONE;
              end else begin
                mcu_x_d = '0;
                mcu_y_d = mcu_y_q + MCUW'(1);
              end
            end else begin
              mcu_x_d = mcu_x_q + MCUW'(1);
            end
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ProcessInit overrides everything evaluated above in the same cycle.
    if (ProcessInit) begin
      state_d    = IDLE;
      ptr_d      = 3'd0;
      mcu_x_d    = '0;
      mcu_y_d    = '0;
      mcu_cols_d = '0;
      mcu_rows_d = '0;
      mcu_done_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= GREY;
      width_q    <= '0;
      height_q   <= '0;
      ptr_q      <= 3'd0;
      mcu_x_q    <= '0;
      mcu_y_q    <= '0;
      mcu_cols_q <= '0;
      mcu_rows_q <= '0;
      mcu_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      height_q   <= height_d;
      ptr_q      <= ptr_d;
      mcu_x_q    <= mcu_x_d;
      mcu_y_q    <= mcu_y_d;
      mcu_cols_q <= mcu_cols_d;
      mcu_rows_q <= mcu_rows_d;
      mcu_done_q <= mcu_done_d;
      err_q      <= err_d;
    end
  end

  assign BlockReady = block_ready;
  assign BlockColor = slot;
  assign McuX       = mcu_x_q;
  assign McuY       = mcu_y_q;
  assign McuCols    = mcu_cols_q;
  assign McuDone    = mcu_done_q;
  assign FrameDone  = (state_q == DONE);
  assign Busy       = (state_q != IDLE);
  assign ErrOverrun = err_q;

`ifdef AQ_DJPEG_MCU_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Restarts with every accepted frame and holds at all-ones once saturated.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == RUN) && !block_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if ((state_q == IDLE) && Start) begin
      stall_d = '0;
    end
    if (ProcessInit) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign StallCycles = stall_q;
`endif

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Self-checking testbench for aq_djpeg_mcu_seq. A reference model derives the
// slot order and MCU grid of each frame from the configuration with plain
// arithmetic; stimulus gaps and BankFull are randomized.
module tb_aq_djpeg_mcu_seq;

  localparam int MCUW = 12;
  localparam int DIMW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ProcessInit = 1'b0;
  logic            Start = 1'b0;
  logic [2:0]      JpegComp = '0;
  logic [1:0]      SubSamplingW = '0;
  logic [1:0]      SubSamplingH = '0;
  logic [DIMW-1:0] ImageWidth = '0;
  logic [DIMW-1:0] ImageHeight = '0;
  logic            BankFull = 1'b0;
  logic            BlockDone = 1'b0;
  logic            BlockReady;
  logic [2:0]      BlockColor;
  logic [MCUW-1:0] McuX;
  logic [MCUW-1:0] McuY;
  logic [MCUW-1:0] McuCols;
  logic            McuDone;
  logic            FrameDone;
  logic            Busy;
  logic            ErrOverrun;
`ifdef AQ_DJPEG_MCU_STATS_EN
  logic [31:0]     StallCycles;
`endif

  int total = 0;
  int bad = 0;

  int exp_seq[$];
  int exp_cols;
  int exp_rows;

  aq_djpeg_mcu_seq #(.MCUW(MCUW), .DIMW(DIMW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ProcessInit  (ProcessInit),
    .Start        (Start),
    .JpegComp     (JpegComp),
    .SubSamplingW (SubSamplingW),
    .SubSamplingH (SubSamplingH),
    .ImageWidth   (ImageWidth),
    .ImageHeight  (ImageHeight),
    .BankFull     (BankFull),
    .BlockDone    (BlockDone),
    .BlockReady   (BlockReady),
    .BlockColor   (BlockColor),
    .McuX         (McuX),
    .McuY         (McuY),
    .McuCols      (McuCols),
    .McuDone      (McuDone),
    .FrameDone    (FrameDone),
    .Busy         (Busy),
    .ErrOverrun   (ErrOverrun)
`ifdef AQ_DJPEG_MCU_STATS_EN
    ,
    .StallCycles  (StallCycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a colour MCU holds its Y blocks in raster order of a 2x2 grid
  // (index = row*2 + col) followed by Cb and Cr; grey uses four Y banks.
  task automatic model_setup(input int comp, input int sw, input int sh,
                             input int w, input int h);
    int fw, fh, pw, ph;
    exp_seq.delete();
    if (comp != 3) begin
      for (int i = 0; i < 4; i++) exp_seq.push_back(i);
      pw = 32;
      ph = 8;
    end else begin
      fw = (sw == 2) ? 2 : 1;
      fh = (sh == 2) ? 2 : 1;
      for (int v = 0; v < fh; v++)
        for (int u = 0; u < fw; u++)
          exp_seq.push_back(v * 2 + u);
      exp_seq.push_back(4);
      exp_seq.push_back(5);
      pw = 8 * fw;
      ph = 8 * fh;
    end
    exp_cols = ((w + pw - 1) / pw) % 4096;
    exp_rows = ((h + ph - 1) / ph) % 4096;
  endtask

  task automatic start_frame(input int comp, input int sw, input int sh,
                             input int w, input int h);
    JpegComp     = 3'(comp);
    SubSamplingW = 2'(sw);
    SubSamplingH = 2'(sh);
    ImageWidth   = DIMW'(w);
    ImageHeight  = DIMW'(h);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    // Scramble the configuration; the frame must keep what was sampled.
    JpegComp     = 3'($urandom);
    SubSamplingW = 2'($urandom);
    SubSamplingH = 2'($urandom);
    ImageWidth   = DIMW'($urandom);
    ImageHeight  = DIMW'($urandom);
    tick();
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_busy: got %0b expected 1", Busy);
    end
    total++;
    if (McuCols !== MCUW'(exp_cols)) begin
      bad++;
      $display("[TB] FAIL mcu_cols: got %0d expected %0d", McuCols, exp_cols);
    end
  endtask

  // Runs a whole frame; glitch_at >= 0 also pulses Start with a different
  // configuration together with that block's BlockDone.
  task automatic run_frame(input int comp, input int sw, input int sh,
                           input int w, input int h, input int glitch_at);
    int n, nblk, waits, nseq;
    logic bf, exp_rdy;
    model_setup(comp, sw, sh, w, h);
    start_frame(comp, sw, sh, w, h);
    nseq = exp_seq.size();
    nblk = exp_cols * exp_rows * nseq;
    n = 0;
    for (int y = 0; y < exp_rows; y++) begin
      for (int x = 0; x < exp_cols; x++) begin
        for (int i = 0; i < nseq; i++) begin
          waits = int'($urandom_range(0, 2));
          for (int k = 0; k <= waits; k++) begin
            if (k < waits) begin
              bf = 1'($urandom_range(0, 1));
              BankFull = bf;
              exp_rdy = (i != 0) || !bf;
            end else begin
              BankFull = (i != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
              BlockDone = 1'b1;
              if (n == glitch_at) begin
                Start = 1'b1;
                JpegComp = (comp == 3) ? 3'd0 : 3'd3;
                SubSamplingW = 2'd2;
                SubSamplingH = 2'd2;
                ImageWidth = 16'd999;
              end
              exp_rdy = 1'b1;
            end
            #1;
            total++;
            if (BlockReady !== exp_rdy) begin
              bad++;
              $display("[TB] FAIL block_ready blk=%0d: got %0b expected %0b", n, BlockReady, exp_rdy);
            end
            total++;
            if (BlockColor !== 3'(exp_seq[i])) begin
              bad++;
              $display("[TB] FAIL block_color blk=%0d: got %0d expected %0d", n, BlockColor, exp_seq[i]);
            end
            total++;
            if ((McuX !== MCUW'(x)) || (McuY !== MCUW'(y))) begin
              bad++;
              $display("[TB] FAIL mcu_pos blk=%0d: got %0d,%0d expected %0d,%0d", n, McuX, McuY, x, y);
            end
            tick();
          end
          BlockDone = 1'b0;
          BankFull = 1'b0;
          Start = 1'b0;
          total++;
          if (McuDone !== (i == nseq - 1)) begin
            bad++;
            $display("[TB] FAIL mcu_done blk=%0d: got %0b expected %0b", n, McuDone, (i == nseq - 1));
          end
          total++;
          if (FrameDone !== (n == nblk - 1)) begin
            bad++;
            $display("[TB] FAIL frame_done blk=%0d: got %0b expected %0b", n, FrameDone, (n == nblk - 1));
          end
          n++;
        end
      end
    end
    tick();
    total++;
    if ((Busy !== 1'b0) || (FrameDone !== 1'b0) || (ErrOverrun !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL frame_end: got busy=%0b fd=%0b err=%0b expected 0 0 0", Busy, FrameDone, ErrOverrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Start = 1'b1;
    BlockDone = 1'b1;
    JpegComp = 3'd3;
    tick();
    tick();
    rst = 1'b0;
    Start = 1'b0;
    BlockDone = 1'b0;
    tick();
    total++;
    if ({Busy, BlockReady, McuDone, FrameDone, ErrOverrun} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {Busy, BlockReady, McuDone, FrameDone, ErrOverrun});
    end
    total++;
    if ((BlockColor !== 3'd0) || (McuX !== '0) || (McuY !== '0) || (McuCols !== '0)) begin
      bad++;
      $display("[TB] FAIL reset_values: got color=%0d x=%0d y=%0d cols=%0d expected 0", BlockColor, McuX, McuY, McuCols);
    end
`ifdef AQ_DJPEG_MCU_STATS_EN
    total++;
    if (StallCycles !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_stall: got %0d expected 0", StallCycles);
    end
`endif
  endtask

  task automatic test_w2h2();
    run_frame(3, 2, 2, 16, 16, -1);
  endtask

  task automatic test_w1h1();
    run_frame(3, 1, 1, 20, 8, -1);
  endtask

  task automatic test_grey();
    run_frame(0, 0, 0, 64, 16, -1);
  endtask

  task automatic test_overrun();
    model_setup(3, 2, 1, 16, 8);
    start_frame(3, 2, 1, 16, 8);
    for (int c = 0; c < 5; c++) begin
      BankFull = 1'b1;
      BlockDone = (c == 2);
      #1;
      total++;
      if (BlockReady !== 1'b0) begin
        bad++;
        $display("[TB] FAIL overrun_ready c=%0d: got %0b expected 0", c, BlockReady);
      end
      tick();
      BlockDone = 1'b0;
    end
`ifdef AQ_DJPEG_MCU_STATS_EN
    total++;
    if (StallCycles !== 32'd5) begin
      bad++;
      $display("[TB] FAIL stall_cycles: got %0d expected 5", StallCycles);
    end
`endif
    BankFull = 1'b0;
    #1;
    total++;
    if ((ErrOverrun !== 1'b1) || (BlockColor !== 3'd0) || (BlockReady !== 1'b1)) begin
      bad++;
      $display("[TB] FAIL overrun_state: got err=%0b color=%0d rdy=%0b expected 1 0 1", ErrOverrun, BlockColor, BlockReady);
    end
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
    total++;
    if ((ErrOverrun !== 1'b0) || (Busy !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL overrun_clear: got err=%0b busy=%0b expected 0 0", ErrOverrun, Busy);
    end
`ifdef AQ_DJPEG_MCU_STATS_EN
    total++;
    if (StallCycles !== 32'd0) begin
      bad++;
      $display("[TB] FAIL stall_clear: got %0d expected 0", StallCycles);
    end
`endif
  endtask

  task automatic test_process_init();
    model_setup(3, 2, 1, 48, 8);
    start_frame(3, 2, 1, 48, 8);
    BankFull = 1'b1;
    BlockDone = 1'b1;
    tick();
    BankFull = 1'b0;
    BlockDone = 1'b0;
    total++;
    if (ErrOverrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pinit_err_set: got %0b expected 1", ErrOverrun);
    end
    for (int i = 0; i < 6; i++) begin
      BlockDone = 1'b1;
      tick();
    end
    BlockDone = 1'b0;
    total++;
    if ((BlockColor !== 3'(exp_seq[2])) || (McuX !== MCUW'(1))) begin
      bad++;
      $display("[TB] FAIL pinit_mid: got color=%0d x=%0d expected %0d 1", BlockColor, McuX, exp_seq[2]);
    end
    ProcessInit = 1'b1;
    BlockDone = 1'b1;
    tick();
    ProcessInit = 1'b0;
    BlockDone = 1'b0;
    total++;
    if ((Busy !== 1'b0) || (McuX !== '0) || (ErrOverrun !== 1'b0) || (BlockColor !== 3'd0) || (McuDone !== 1'b0)) begin
      bad++;
      $display("[TB] FAIL pinit_abort: got busy=%0b x=%0d err=%0b color=%0d md=%0b expected all 0",
               Busy, McuX, ErrOverrun, BlockColor, McuDone);
    end
    run_frame(3, 2, 1, 48, 8, -1);
  endtask

  task automatic test_start_ignored();
    run_frame(3, 2, 2, 16, 16, 2);
    run_frame(0, 0, 0, 40, 9, 5);
  endtask

  task automatic test_boundary();
    model_setup(3, 1, 1, 65535, 1);
    start_frame(3, 1, 1, 65535, 1);
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
    model_setup(0, 0, 0, 65535, 1);
    start_frame(0, 0, 0, 65535, 1);
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
    run_frame(3, 0, 3, 1, 1, -1);
  endtask

  task automatic test_random();
    int comp, sw, sh, w, h;
    for (int r = 0; r < 5; r++) begin
      comp = ($urandom_range(0, 2) != 0) ? 3 : int'($urandom_range(0, 7));
      sw = int'($urandom_range(0, 3));
      sh = int'($urandom_range(0, 3));
      w = int'($urandom_range(1, 80));
      h = int'($urandom_range(1, 48));
      run_frame(comp, sw, sh, w, h, -1);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(3, 2, 1, 33, 8, -1);
    run_frame(3, 1, 2, 8, 17, -1);
    run_frame(0, 0, 0, 33, 8, -1);
  endtask

  initial begin
    test_reset();
    test_w2h2();
    test_w1h1();
    test_grey();
    test_overrun();
    test_process_init();
    test_start_ignored();
    test_boundary();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_mcu_seq.md
Name: aq_djpeg_mcu_seq

Overview:
- Scheduler ahead of the YCbCr memory / colour-conversion path.
- Sequences IDCT block completions into MCU slots: Y0..Y3 = 0..3, Cb = 4, Cr = 5.
- Gates upstream block start on bank availability, tracks the MCU X/Y position and signals MCU and frame completion.
- Replaces ad-hoc slot counting with one decided, sampling-aware sequencer.

Parameters:
- MCUW, 12, width of MCU X/Y counters and MCU-count outputs.
- DIMW, 16, width of image dimension inputs.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- ProcessInit  in  1  restart pulse: abort and return to IDLE.
- Start  in  1  pulse: latch configuration and begin a frame.
- JpegComp  in  3  3 = YCbCr; any other value = grey.
- SubSamplingW  in  2  horizontal Y factor; 2 means 2, any other value means 1.
- SubSamplingH  in  2  vertical Y factor; same coding as SubSamplingW.
- ImageWidth  in  DIMW  pixels, must be ≥1.
- ImageHeight  in  DIMW  pixels, must be ≥1.
- BankFull  in  1  YCbCr memory cannot accept a new bank.
- BlockDone  in  1  pulse: last word of a block written (page 7, count 3).
- BlockReady  out  1  upstream may produce/finish the current block.
- BlockColor  out  3  slot index of the current block.
- McuX  out  MCUW  current MCU column.
- McuY  out  MCUW  current MCU row.
- McuCols  out  MCUW  MCUs per row, computed at Start.
- McuDone  out  1  one-cycle pulse when an MCU's last block is accepted.
- FrameDone  out  1  one-cycle pulse when the last MCU completes.
- Busy  out  1  high outside IDLE.
- ErrOverrun  out  1  sticky; BlockDone seen while BlockReady = 0.

Behaviour:
- Reset (rst = 1 at posedge): state IDLE; all outputs 0 except BlockColor = 0.
- ProcessInit: same effect as reset, except ErrOverrun is also cleared. ProcessInit wins over Start and BlockDone in the same cycle.
- Slot sequences, fixed at Start:
  - grey: 0,1,2,3 (a bank is 32x8 px);
  - colour W1H1: 0,4,5;
  - colour W2H1: 0,1,4,5;
  - colour W1H2: 0,2,4,5;
  - colour W2H2: 0,1,2,3,4,5.
- MCU pixel size: grey 32x8; colour (8·W)x(8·H).
- McuCols = ceil(ImageWidth / MCU pixel width). McuRows = ceil(ImageHeight / MCU pixel height), held internally. Both are computed with shifts and round-up and are truncated to MCUW.
- States:
  - IDLE: Start → CALC.
  - CALC: 1 cycle; latches McuCols/McuRows; McuX = McuY = 0; slot pointer = 0 → RUN.
  - RUN:
    - BlockReady = (slot pointer ≠ 0) OR !BankFull.
    - BankFull is only checked at bank start; mid-MCU blocks never stall.
    - BlockColor = sequence[slot pointer].
    - BlockDone with BlockReady = 1 advances the slot pointer.
    - On the last slot: pointer wraps to 0, McuDone pulses the next cycle, and McuX increments.
    - McuX wraps at McuCols−1 → McuX = 0 and McuY increments.
    - If McuX = McuCols−1 and McuY = McuRows−1 on the last slot → DONE.
    - BlockDone with BlockReady = 0 is ignored and sets ErrOverrun.
  - DONE: FrameDone pulses 1 cycle (coincident with the final McuDone) → IDLE.
- Start while Busy is ignored.
- Configuration inputs are sampled only in IDLE on Start; later changes have no effect until the next frame.
- Latency: BlockDone → BlockColor/McuX update 1 cycle. BankFull → BlockReady is combinational from registered state.

Optional Feature:
- Macro AQ_DJPEG_MCU_STATS_EN.
- Defined: adds output StallCycles (32 bits). It counts cycles in RUN with BlockReady = 0, saturates at 0xFFFFFFFF, and is cleared by reset, ProcessInit and Start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package aq_djpeg_pkg holds:
  - slot encodings SLOT_Y0..SLOT_Y3 = 0..3, SLOT_CB = 4, SLOT_CR = 5;
  - state encodings IDLE / CALC / RUN / DONE;
  - sampling-mode enum GREY / S444 / S422 / S440 / S420.
- Sub-module aq_djpeg_mcu_slot_rom: combinational map (mode, pointer) → (slot, last flag).

Test Plan:
- Colour W2H2, 16x16 image, BankFull = 0, 6 BlockDone pulses → BlockColor 0,1,2,3,4,5; one McuDone; FrameDone on the 6th; McuCols = 1.
- Colour W1H1, 20x8 image → McuCols = 3; 9 BlockDone pulses give BlockColor 0,4,5 ×3; McuX 0→1→2; FrameDone after the 9th.
- Grey, 64x16 image → McuCols = 2, McuRows = 2; 16 BlockDone pulses; McuY increments after the 8th; 4 McuDone pulses.
- BankFull = 1 at slot 0 for 5 cycles; BlockDone pulsed during that window → BlockReady = 0, ErrOverrun = 1, pointer stays 0; with STATS_EN, StallCycles = 5.
- W2H1 mid-frame (pointer = 2), ProcessInit and BlockDone in the same cycle → IDLE, Busy = 0, McuX = 0, ErrOverrun = 0; next Start restarts at slot 0.
- Start asserted in RUN with different JpegComp → ignored; the sequence continues unchanged.
